mutative_refill_ctrl: RTL and testbench

Miss-handling and refill controller for the mutative cache; sits directly downstream of the replacement unit. On a lookup miss it latches the victim way chosen by the replacement unit, writes back the victim line if it is dirty, fetches the missing line from memory, and installs it into the data/tag arrays through the replacement unit's one-hot way-enable. While busy, it holds off geometry (setup) changes and counts misses and writebacks.

---
 rtl/mutative_refill_ctrl_if.sv | 59 +++++
 rtl/mutative_refill_ctrl.sv | 140 ++++++++++++++
 tb/tb_mutative_refill_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mutative_refill_ctrl_if.sv
// rtl/mutative_refill_ctrl_if.sv - requester/array/memory bundle for the refill controller
interface mutative_refill_ctrl_if #(
  parameter int ADDR_BITS    = 32,
  parameter int OFFSET_BITS  = 5,
  parameter int SET_IDX_BITS = 4,
  parameter int TAG_BITS     = ADDR_BITS - OFFSET_BITS - SET_IDX_BITS,
  parameter int WAYS         = 8,
  parameter int WAY_IDX_BITS = 3,
  parameter int LINE_BITS    = 256,
  parameter int CNT_BITS     = 16
);
  // requester and replacement unit
  logic                    miss_req;
  logic [ADDR_BITS-1:0]    miss_addr;
  logic [WAY_IDX_BITS-1:0] evict_way;
  logic [WAYS-1:0]         evict_we;
  // victim read-back from the arrays
  logic                    victim_valid;
  logic                    victim_dirty;
  logic [TAG_BITS-1:0]     victim_tag;
  logic [LINE_BITS-1:0]    victim_data;
  // array access
  logic                    array_rd_en;
  logic [WAY_IDX_BITS-1:0] array_rd_way;
  logic [SET_IDX_BITS-1:0] array_set;
  logic [WAYS-1:0]         array_we;
  logic [TAG_BITS-1:0]     array_wtag;
  logic [LINE_BITS-1:0]    array_wdata;
  // memory side
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic [LINE_BITS-1:0]    mem_wdata;
  logic [LINE_BITS-1:0]    mem_rdata;
  logic                    mem_resp;
  // status
  logic                    busy;
  logic                    miss_done;
  logic [CNT_BITS-1:0]     miss_count;
  logic [CNT_BITS-1:0]     wb_count;

  modport master (
    output miss_req, miss_addr, evict_way, evict_we,
    output victim_valid, victim_dirty, victim_tag, victim_data,
    output mem_rdata, mem_resp,
    input  array_rd_en, array_rd_way, array_set, array_we, array_wtag, array_wdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy, miss_done, miss_count, wb_count
  );

  modport slave (
    input  miss_req, miss_addr, evict_way, evict_we,
    input  victim_valid, victim_dirty, victim_tag, victim_data,
    input  mem_rdata, mem_resp,
    output array_rd_en, array_rd_way, array_set, array_we, array_wtag, array_wdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy, miss_done, miss_count, wb_count
  );
endinterface

// File: rtl/mutative_refill_ctrl.sv
// rtl/mutative_refill_ctrl.sv - miss handling, victim writeback and line refill controller
module mutative_refill_ctrl #(
  parameter int ADDR_BITS    = 32,
  parameter int OFFSET_BITS  = 5,
  parameter int SET_IDX_BITS = 4,
  parameter int TAG_BITS     = ADDR_BITS - OFFSET_BITS - SET_IDX_BITS,
  parameter int WAYS         = 8,
  parameter int WAY_IDX_BITS = 3,
  parameter int LINE_BITS    = 256,
  parameter int CNT_BITS     = 16
) (
  input logic                  clk,
  input logic                  rst,
  mutative_refill_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_VICTIM, S_WRITEBACK, S_FILL, S_INSTALL, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic [TAG_BITS-1:0]     r_tag;
  logic [SET_IDX_BITS-1:0] r_set;
  logic [WAY_IDX_BITS-1:0] r_way;
  logic [WAYS-1:0]         r_we;
  logic [TAG_BITS-1:0]     r_vic_tag;
  logic [LINE_BITS-1:0]    r_vic_data;
  logic [LINE_BITS-1:0]    r_line;
  logic [CNT_BITS-1:0]     r_miss_cnt;
  logic [CNT_BITS-1:0]     r_wb_cnt;

  logic                    w_accept;
  logic                    w_vic_dirty;
  logic [TAG_BITS-1:0]     w_req_tag;
  logic [SET_IDX_BITS-1:0] w_req_set;
  logic                    w_unused_offset;

  assign w_accept    = (r_state == S_IDLE) && bus.miss_req;
  assign w_vic_dirty = bus.victim_valid && bus.victim_dirty;
  assign w_req_tag   = bus.miss_addr[ADDR_BITS-1 -: TAG_BITS];
  assign w_req_set   = bus.miss_addr[OFFSET_BITS +: SET_IDX_BITS];
  // the byte offset of a miss never matters: every memory request is line aligned
  assign w_unused_offset = ^bus.miss_addr[OFFSET_BITS-1:0];

  assign bus.miss_count = r_miss_cnt;
  assign bus.wb_count   = r_wb_cnt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state: memory phases wait for mem_resp, everything else advances each cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (bus.miss_req) w_next = S_VICTIM;
      S_VICTIM:    w_next = w_vic_dirty ? S_WRITEBACK : S_FILL;
      S_WRITEBACK: if (bus.mem_resp) w_next = S_FILL;
      S_FILL:      if (bus.mem_resp) w_next = S_INSTALL;
      S_INSTALL:   w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // holding registers and saturating counters; way/enable frozen at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag      <= '0;
      r_set      <= '0;
      r_way      <= '0;
      r_we       <= '0;
      r_vic_tag  <= '0;
      r_vic_data <= '0;
      r_line     <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_tag <= w_req_tag;
        r_set <= w_req_set;
        r_way <= bus.evict_way;
        r_we  <= bus.evict_we;
        if (r_miss_cnt != {CNT_BITS{1'b1}}) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if (r_state == S_VICTIM) begin
        r_vic_tag  <= bus.victim_tag;
        r_vic_data <= bus.victim_data;
        if (w_vic_dirty && (r_wb_cnt != {CNT_BITS{1'b1}})) r_wb_cnt <= r_wb_cnt + 1'b1;
      end
      if ((r_state == S_FILL) && bus.mem_resp) r_line <= bus.mem_rdata;
    end
  end

  // outputs: array read is issued combinationally in the accepting cycle
  always_comb begin
    bus.array_rd_en  = 1'b0;
    bus.array_rd_way = r_way;
    bus.array_set    = r_set;
    bus.array_we     = '0;
    bus.array_wtag   = '0;
    bus.array_wdata  = '0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.busy         = (r_state != S_IDLE);
    bus.miss_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.miss_req) begin
          bus.array_rd_en  = 1'b1;
          bus.array_rd_way = bus.evict_way;
          bus.array_set    = w_req_set;
        end
      end
      S_WRITEBACK: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {r_vic_tag, r_set, {OFFSET_BITS{1'b0}}};
        bus.mem_wdata = r_vic_data;
      end
      S_FILL: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {r_tag, r_set, {OFFSET_BITS{1'b0}}};
      end
      S_INSTALL: begin
        bus.array_we    = r_we;
        bus.array_wtag  = r_tag;
        bus.array_wdata = r_line;
      end
      S_DONE:  bus.miss_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mutative_refill_ctrl.sv
// tb/tb_mutative_refill_ctrl.sv - directed self-checking bench for mutative_refill_ctrl
module tb_mutative_refill_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  logic mon_en  = 1'b0;
  int   we_seen = 0;

  always #5 clk = ~clk;

  mutative_refill_ctrl_if bus ();
  mutative_refill_ctrl_if #(.CNT_BITS(4)) b2 ();

  mutative_refill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  mutative_refill_ctrl #(.CNT_BITS(4)) dut_sat (.clk(clk), .rst(rst), .bus(b2));

  always @(posedge clk) if (mon_en && (bus.array_we != '0)) we_seen <= we_seen + 1;

  localparam logic [255:0] LINE_A = {8{32'hA5A5_0001}};
  localparam logic [255:0] LINE_V = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] LINE_F = {8{32'h0F0F_1234}};
  localparam logic [255:0] LINE_L = {8{32'h3C3C_5A5A}};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.miss_req = 0; bus.miss_addr = '0; bus.evict_way = '0; bus.evict_we = '0;
    bus.victim_valid = 0; bus.victim_dirty = 0; bus.victim_tag = '0; bus.victim_data = '0;
    bus.mem_rdata = '0; bus.mem_resp = 0;
    b2.miss_req = 0; b2.miss_addr = '0; b2.evict_way = '0; b2.evict_we = '0;
    b2.victim_valid = 0; b2.victim_dirty = 0; b2.victim_tag = '0; b2.victim_data = '0;
    b2.mem_rdata = '0; b2.mem_resp = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
    @(negedge clk);
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
    n_total++; if ({bus.mem_read, bus.mem_write, bus.miss_done, bus.array_rd_en} !== 4'b0)
      $display("FAIL reset_ctrl got %b want 0000", {bus.mem_read, bus.mem_write, bus.miss_done, bus.array_rd_en}); else n_pass++;
    n_total++; if ({bus.miss_count, bus.wb_count} !== 32'h0)
      $display("FAIL reset_counts got %h want 0", {bus.miss_count, bus.wb_count}); else n_pass++;
    n_total++; if ((bus.array_we !== 8'h0) || (bus.mem_addr !== 32'h0))
      $display("FAIL reset_bus got we=%h addr=%h want 0", bus.array_we, bus.mem_addr); else n_pass++;
  endtask

  task automatic test_clean_miss;
    tick();
    bus.miss_req = 1; bus.miss_addr = 32'h0000_1240; bus.evict_way = 3'd5; bus.evict_we = 8'h20;
    bus.victim_valid = 0; bus.victim_dirty = 1;
    @(negedge clk);
    n_total++; if ({bus.array_rd_en, bus.array_rd_way, bus.array_set} !== {1'b1, 3'd5, 4'd2})
      $display("FAIL clean_rd got %b/%0d/%0d want 1/5/2", bus.array_rd_en, bus.array_rd_way, bus.array_set); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.mem_read, bus.mem_write} !== 3'b100)
      $display("FAIL clean_victim got %b want 100", {bus.busy, bus.mem_read, bus.mem_write}); else n_pass++;
    tick();
    bus.mem_resp = 1; bus.mem_rdata = LINE_A;
    @(negedge clk);
    n_total++; if ({bus.mem_read, bus.mem_write, bus.mem_addr} !== {2'b10, 32'h0000_1240})
      $display("FAIL clean_fill got %b addr=%h want 10 addr=00001240", {bus.mem_read, bus.mem_write}, bus.mem_addr); else n_pass++;
    tick();
    bus.mem_resp = 0; bus.mem_rdata = '0;
    @(negedge clk);
    n_total++; if ((bus.array_we !== 8'h20) || (bus.array_wtag !== 23'h9) || (bus.array_wdata !== LINE_A) || bus.miss_done)
      $display("FAIL clean_install got we=%h tag=%h done=%b want we=20 tag=9", bus.array_we, bus.array_wtag, bus.miss_done); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({bus.miss_done, bus.busy, bus.array_we} !== {2'b11, 8'h00})
      $display("FAIL clean_done got done=%b busy=%b we=%h want 1 1 00", bus.miss_done, bus.busy, bus.array_we); else n_pass++;
    bus.miss_req = 0;
    tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.miss_count, bus.wb_count} !== {1'b0, 16'd1, 16'd0})
      $display("FAIL clean_counts got busy=%b miss=%0d wb=%0d want 0 1 0", bus.busy, bus.miss_count, bus.wb_count); else n_pass++;
  endtask

  task automatic test_dirty_miss;
    tick();
    bus.miss_req = 1; bus.miss_addr = 32'h0000_A040; bus.evict_way = 3'd2; bus.evict_we = 8'h04;
    bus.victim_valid = 1; bus.victim_dirty = 1; bus.victim_tag = 23'h12; bus.victim_data = LINE_V;
    tick(); // VICTIM
    tick(); // WRITEBACK 1
    bus.victim_tag = 23'h7; bus.victim_data = '0; bus.victim_dirty = 0;
    @(negedge clk);
    n_total++; if ({bus.mem_write, bus.mem_read, bus.mem_addr} !== {2'b10, 32'h0000_2440} || (bus.mem_wdata !== LINE_V))
      $display("FAIL dirty_wb got w=%b r=%b addr=%h want 1 0 00002440", bus.mem_write, bus.mem_read, bus.mem_addr); else n_pass++;
    tick(); // WRITEBACK 2
    tick(); // WRITEBACK 3
    bus.mem_resp = 1;
    @(negedge clk);
    n_total++; if (bus.mem_write !== 1'b1) $display("FAIL dirty_wb_hold got %b want 1", bus.mem_write); else n_pass++;
    tick(); // FILL 1
    bus.mem_resp = 0; bus.evict_way = 3'd7; bus.evict_we = 8'h80;
    @(negedge clk);
    n_total++; if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.wb_count} !== {2'b10, 32'h0000_A040, 16'd1})
      $display("FAIL dirty_fill got r=%b w=%b addr=%h wb=%0d want 1 0 0000a040 1", bus.mem_read, bus.mem_write, bus.mem_addr, bus.wb_count); else n_pass++;
    tick(); // FILL 2
    tick(); // FILL 3
    bus.mem_resp = 1; bus.mem_rdata = LINE_F;
    tick(); // INSTALL
    bus.mem_resp = 0; bus.mem_rdata = '0;
    @(negedge clk);
    n_total++; if ((bus.array_we !== 8'h04) || (bus.array_wtag !== 23'h50) || (bus.array_wdata !== LINE_F))
      $display("FAIL dirty_install got we=%h tag=%h want we=04 tag=50", bus.array_we, bus.array_wtag); else n_pass++;
    tick(); // DONE
    bus.miss_req = 0;
    @(negedge clk);
    n_total++; if (bus.miss_done !== 1'b1) $display("FAIL dirty_done got %b want 1", bus.miss_done); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.miss_count, bus.wb_count} !== {1'b0, 16'd2, 16'd1})
      $display("FAIL dirty_counts got busy=%b miss=%0d wb=%0d want 0 2 1", bus.busy, bus.miss_count, bus.wb_count); else n_pass++;
  endtask

  task automatic test_reset_mid;
    mon_en = 1;
    bus.miss_req = 1; bus.miss_addr = 32'h0000_A040; bus.evict_way = 3'd1; bus.evict_we = 8'h02;
    bus.victim_valid = 1; bus.victim_dirty = 1; bus.victim_tag = 23'h12; bus.victim_data = LINE_V;
    tick(); // VICTIM
    tick(); // WRITEBACK
    @(negedge clk);
    n_total++; if (bus.mem_write !== 1'b1) $display("FAIL rstmid_wb got %b want 1", bus.mem_write); else n_pass++;
    rst = 1; bus.miss_req = 0;
    tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.mem_write, bus.mem_read, bus.miss_count, bus.wb_count} !== 35'h0)
      $display("FAIL rstmid_state got busy=%b w=%b miss=%0d wb=%0d want 0", bus.busy, bus.mem_write, bus.miss_count, bus.wb_count); else n_pass++;
    rst = 0; bus.victim_valid = 0; bus.victim_dirty = 0;
    repeat (4) tick();
    mon_en = 0;
    n_total++; if (we_seen !== 0) $display("FAIL rstmid_we got %0d writes want 0", we_seen); else n_pass++;
  endtask

  task automatic test_stray_resp;
    int  cyc;
    bit  installed;
    bus.mem_resp = 1; bus.mem_rdata = LINE_L;
    tick(); tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.mem_read, bus.array_we} !== 10'h0)
      $display("FAIL stray_idle got busy=%b r=%b we=%h want 0", bus.busy, bus.mem_read, bus.array_we); else n_pass++;
    bus.miss_req = 1; bus.miss_addr = 32'h0000_3460; bus.evict_way = 3'd1; bus.evict_we = 8'h02;
    installed = 0; cyc = 0;
    while (cyc < 20) begin
      tick(); cyc++;
      @(negedge clk);
      if ((bus.array_we == 8'h02) && (bus.array_wtag == 23'h1A) && (bus.array_wdata == LINE_L)) installed = 1;
      if (bus.miss_done) break;
    end
    n_total++; if (cyc !== 4) $display("FAIL stray_latency got %0d cycles want 4", cyc); else n_pass++;
    n_total++; if (bus.array_rd_en !== 1'b0) $display("FAIL stray_done_rd got %b want 0", bus.array_rd_en); else n_pass++;
    n_total++; if (installed !== 1'b1) $display("FAIL stray_install got %b want 1", installed); else n_pass++;
    bus.miss_req = 0;
    tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.miss_count} !== {1'b0, 16'd1})
      $display("FAIL stray_count got busy=%b miss=%0d want 0 1", bus.busy, bus.miss_count); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int  cyc;
    int  first;
    int  second;
    bit  prev_done;
    logic [1:0] gap_state;
    bus.miss_req = 1; bus.mem_resp = 1; bus.victim_valid = 0;
    cyc = 0; first = -1; second = -1; prev_done = 0; gap_state = 2'b00;
    while (cyc < 30 && second < 0) begin
      tick(); cyc++;
      @(negedge clk);
      if (prev_done) gap_state = {bus.busy, bus.array_rd_en};
      prev_done = bus.miss_done;
      if (bus.miss_done) begin
        if (first < 0) first = cyc;
        else begin second = cyc; bus.miss_req = 0; end
      end
    end
    bus.miss_req = 0; bus.mem_resp = 0;
    n_total++; if ((second - first) !== 5) $display("FAIL b2b_gap got %0d want 5", second - first); else n_pass++;
    n_total++; if (gap_state !== 2'b01) $display("FAIL b2b_idle got busy,rd=%b want 01", gap_state); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if ({bus.busy, bus.miss_count} !== {1'b0, 16'd3})
      $display("FAIL b2b_count got busy=%b miss=%0d want 0 3", bus.busy, bus.miss_count); else n_pass++;
  endtask

  task automatic test_saturation;
    int cyc;
    b2.miss_req = 1; b2.victim_valid = 1; b2.victim_dirty = 1; b2.mem_resp = 1;
    repeat (120) tick();
    b2.miss_req = 0;
    cyc = 0;
    while (b2.busy && cyc < 20) begin tick(); cyc++; end
    @(negedge clk);
    n_total++; if (b2.busy !== 1'b0) $display("FAIL sat_idle got busy=%b want 0", b2.busy); else n_pass++;
    n_total++; if (b2.miss_count !== 4'hF) $display("FAIL sat_miss got %h want f", b2.miss_count); else n_pass++;
    n_total++; if (b2.wb_count !== 4'hF) $display("FAIL sat_wb got %h want f", b2.wb_count); else n_pass++;
    b2.mem_resp = 0; b2.victim_valid = 0; b2.victim_dirty = 0;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid();
    test_stray_resp();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
